// File: rtl/keypad_pkg.sv
// Shared types and constants for the keypad digit-entry block.
package keypad_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DEBOUNCE,
        HELD,
        RELEASE
    } kp_state_t;

    localparam int KP_CNT_W = 4;

endpackage

// File: rtl/pb_debounce_fsm.sv
// Push-button debounce FSM: accepts a code only after it has been stable for DEBOUNCE edges,
// then waits for a stable release before arming again.
module pb_debounce_fsm
    import keypad_pkg::KP_CNT_W;
#(
    parameter int DEBOUNCE = 2
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [3:0] code_i,
    input  logic       strobe_i,
    output logic       commit_o,
    output logic [3:0] lat_o
);

    localparam logic [KP_CNT_W-1:0] CNT_ONE  = KP_CNT_W'(1);
    localparam logic [KP_CNT_W-1:0] CNT_LAST = KP_CNT_W'(DEBOUNCE - 1);

    keypad_pkg::kp_state_t state_q;
    logic [KP_CNT_W-1:0]   cnt_q;
    logic [3:0]            lat_q;

    // Decoded from current state so the entry register updates on the accepting edge itself.
    assign commit_o = (state_q == keypad_pkg::DEBOUNCE) && strobe_i &&
                      (code_i == lat_q) && (cnt_q == CNT_LAST);
    assign lat_o    = lat_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= keypad_pkg::IDLE;
            cnt_q   <= '0;
            lat_q   <= 4'h0;
        end else begin
            case (state_q)
                keypad_pkg::IDLE: begin
                    if (strobe_i) begin
                        state_q <= keypad_pkg::DEBOUNCE;
                        lat_q   <= code_i;
                        cnt_q   <= CNT_ONE;
                    end
                end
                keypad_pkg::DEBOUNCE: begin
                    if (!strobe_i || (code_i != lat_q)) begin
                        state_q <= keypad_pkg::IDLE;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q <= keypad_pkg::HELD;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                keypad_pkg::HELD: begin
                    if (!strobe_i) begin
                        state_q <= keypad_pkg::RELEASE;
                        cnt_q   <= CNT_ONE;
                    end
                end
                keypad_pkg::RELEASE: begin
                    if (strobe_i) begin
                        state_q <= keypad_pkg::HELD;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q <= keypad_pkg::IDLE;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                default: state_q <= keypad_pkg::IDLE;
            endcase
        end
    end

endmodule

// File: rtl/keypad_digit_entry.sv
// Calculator-style hex entry register fed by a debounced keypad, with clear and backspace.
// Digit 0 is always the newest; unused digit nibbles are held at zero.
module keypad_digit_entry #(
    parameter int NUM_DIGITS = 8,
    parameter int DEBOUNCE   = 2
) (
    input  logic                              hz100,
    input  logic                              reset,
    input  logic [3:0]                        code,
    input  logic                              strobe,
    input  logic                              clr,
    input  logic                              bksp,
    output logic [4*NUM_DIGITS-1:0]           digits,
    output logic [NUM_DIGITS-1:0]             digit_valid,
    output logic [$clog2(NUM_DIGITS+1)-1:0]   count,
    output logic                              press,
    output logic                              overflow
);

    localparam int                CW      = $clog2(NUM_DIGITS + 1);
    localparam logic [CW-1:0]     CNT_ONE = CW'(1);
    localparam logic [CW-1:0]     CNT_MAX = CW'(NUM_DIGITS);

    logic                         commit;
    logic [3:0]                   lat;
    logic                         bksp_edge;

    logic [4*NUM_DIGITS-1:0]      digits_q, digits_d;
    logic [NUM_DIGITS-1:0]        valid_q, valid_d;
    logic [CW-1:0]                count_q, count_d;
    logic                         press_q, press_d;
    logic                         ovf_q, ovf_d;
    logic                         bksp_q;

    pb_debounce_fsm #(
        .DEBOUNCE (DEBOUNCE)
    ) u_fsm (
        .clk_i    (hz100),
        .rst_ni   (reset),
        .code_i   (code),
        .strobe_i (strobe),
        .commit_o (commit),
        .lat_o    (lat)
    );

    assign bksp_edge = bksp & ~bksp_q;

    // clr beats commit beats backspace; a losing backspace edge is simply dropped.
    always_comb begin
        digits_d = digits_q;
        valid_d  = valid_q;
        count_d  = count_q;
        press_d  = 1'b0;
        ovf_d    = 1'b0;
        if (clr) begin
            digits_d = '0;
            valid_d  = '0;
            count_d  = '0;
        end else if (commit) begin
            if (count_q < CNT_MAX) begin
                digits_d = {digits_q[4*NUM_DIGITS-5:0], lat};
                valid_d  = {valid_q[NUM_DIGITS-2:0], 1'b1};
                count_d  = count_q + CNT_ONE;
                press_d  = 1'b1;
            end else begin
                ovf_d = 1'b1;
            end
        end else if (bksp_edge && (count_q != '0)) begin
            digits_d = {4'h0, digits_q[4*NUM_DIGITS-1:4]};
            valid_d  = {1'b0, valid_q[NUM_DIGITS-1:1]};
            count_d  = count_q - CNT_ONE;
        end
    end

    always_ff @(posedge hz100 or negedge reset) begin
        if (!reset) begin
            digits_q <= '0;
            valid_q  <= '0;
            count_q  <= '0;
            press_q  <= 1'b0;
            ovf_q    <= 1'b0;
            bksp_q   <= 1'b0;
        end else begin
            digits_q <= digits_d;
            valid_q  <= valid_d;
            count_q  <= count_d;
            press_q  <= press_d;
            ovf_q    <= ovf_d;
            bksp_q   <= bksp;
        end
    end

    assign digits      = digits_q;
    assign digit_valid = valid_q;
    assign count       = count_q;
    assign press       = press_q;
    assign overflow    = ovf_q;

endmodule

// File: tb/tb_keypad_digit_entry.sv
// Two keypad entry instances (debounce 2 and 3) driven by one stimulus stream and checked
// every cycle against a digit-list model, plus directed literal checks.
module tb_keypad_digit_entry;

    logic       clk;
    logic       rst_n;
    logic [3:0] code;
    logic       strobe;
    logic       clr;
    logic       bksp;

    logic [31:0] dg0, dg1;
    logic [7:0]  v0, v1;
    logic [3:0]  c0, c1;
    logic        p0, p1, o0, o1;

    int n_cmp = 0;
    int n_bad = 0;

    keypad_digit_entry #(.NUM_DIGITS(8), .DEBOUNCE(2)) dut0 (
        .hz100(clk), .reset(rst_n), .code(code), .strobe(strobe), .clr(clr), .bksp(bksp),
        .digits(dg0), .digit_valid(v0), .count(c0), .press(p0), .overflow(o0)
    );

    keypad_digit_entry #(.NUM_DIGITS(8), .DEBOUNCE(3)) dut1 (
        .hz100(clk), .reset(rst_n), .code(code), .strobe(strobe), .clr(clr), .bksp(bksp),
        .digits(dg1), .digit_valid(v1), .count(c1), .press(p1), .overflow(o1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: per instance, a list of entered digits (index 0 = newest) plus run-length
    // counters for how long the key has been steadily pressed / released.
    int         dbv [2] = '{2, 3};
    int         run [2];
    logic [3:0] rcode [2];
    int         held [2];
    int         rel [2];
    bit         bprev [2];
    int         ent [2][8];
    int         n [2];
    bit         e_press [2];
    bit         e_ovf [2];

    function automatic void model_reset(int k);
        run[k] = 0; rcode[k] = 4'h0; held[k] = 0; rel[k] = 0; bprev[k] = 1'b0;
        for (int i = 0; i < 8; i++) ent[k][i] = 0;
        n[k] = 0; e_press[k] = 1'b0; e_ovf[k] = 1'b0;
    endfunction

    function automatic void model_step(int k);
        bit commit = 1'b0;
        bit edge_b;
        if (held[k] != 0) begin
            if (strobe) rel[k] = 0;
            else begin
                rel[k]++;
                if (rel[k] == dbv[k]) begin held[k] = 0; run[k] = 0; end
            end
        end else begin
            if (!strobe || (run[k] > 0 && code != rcode[k])) run[k] = 0;
            else if (run[k] == 0) begin run[k] = 1; rcode[k] = code; end
            else run[k]++;
            if (run[k] == dbv[k]) begin commit = 1'b1; held[k] = 1; rel[k] = 0; run[k] = 0; end
        end
        edge_b = bksp && !bprev[k];
        bprev[k] = bksp;
        e_press[k] = 1'b0;
        e_ovf[k] = 1'b0;
        if (clr) begin
            n[k] = 0;
            for (int i = 0; i < 8; i++) ent[k][i] = 0;
        end else if (commit) begin
            if (n[k] < 8) begin
                for (int i = 7; i > 0; i--) ent[k][i] = ent[k][i-1];
                ent[k][0] = int'(rcode[k]);
                n[k]++;
                e_press[k] = 1'b1;
            end else begin
                e_ovf[k] = 1'b1;
            end
        end else if (edge_b && n[k] > 0) begin
            for (int i = 0; i < 7; i++) ent[k][i] = ent[k][i+1];
            ent[k][7] = 0;
            n[k]--;
        end
    endfunction

    function automatic logic [31:0] exp_digits(int k);
        logic [31:0] r = '0;
        for (int i = 0; i < 8; i++) r[4*i +: 4] = 4'(ent[k][i]);
        return r;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            model_reset(0);
            model_reset(1);
        end else begin
            model_step(0);
            model_step(1);
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: actual=%h required=%h at t=%0t", nm, act, req, $time);
        end
    endtask

    task automatic cmp_dut(input int k, input logic [31:0] dg, input logic [7:0] v,
                           input logic [3:0] c, input logic p, input logic o);
        chk($sformatf("m%0d_digits", k), dg, exp_digits(k));
        chk($sformatf("m%0d_valid", k), 32'(v), 32'((1 << n[k]) - 1));
        chk($sformatf("m%0d_count", k), 32'(c), 32'(n[k]));
        chk($sformatf("m%0d_press", k), 32'(p), 32'(e_press[k]));
        chk($sformatf("m%0d_ovf", k), 32'(o), 32'(e_ovf[k]));
    endtask

    always begin
        @(posedge clk);
        #1;
        cmp_dut(0, dg0, v0, c0, p0, o0);
        cmp_dut(1, dg1, v1, c1, p1, o1);
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic press_key(input logic [3:0] c);
        code = c;
        strobe = 1'b1;
        repeat (4) step();
        strobe = 1'b0;
        repeat (4) step();
    endtask

    initial begin
        rst_n = 1'b0; code = 4'h0; strobe = 1'b0; clr = 1'b0; bksp = 1'b0;
        #3;
        chk("rst_digits_in_reset", dg0, 32'h0);
        #9;
        rst_n = 1'b1;
        step();
        chk("rst_digits", dg0, 32'h0);
        chk("rst_count", 32'(c0), 32'h0);
        chk("rst_valid", 32'(v0), 32'h0);
        chk("rst_press", 32'(p0), 32'h0);

        // Single press of 5: committed on the second edge only.
        code = 4'h5; strobe = 1'b1;
        step(); chk("t2_press_e1", 32'(p0), 32'h0);
        step(); chk("t2_press_e2", 32'(p0), 32'h1);
        chk("t2_digits_e2", dg0, 32'h5);
        step(); chk("t2_press_e3", 32'(p0), 32'h0);
        step();
        strobe = 1'b0;
        repeat (4) step();
        chk("t2_digits", dg0, 32'h5);
        chk("t2_count", 32'(c0), 32'h1);
        chk("t2_valid", 32'(v0), 32'h01);

        // Reset asserted mid-press clears everything immediately.
        code = 4'h6; strobe = 1'b1;
        step();
        #1;
        rst_n = 1'b0; strobe = 1'b0;
        #1;
        chk("t1_digits_async", dg0, 32'h0);
        chk("t1_count_async", 32'(c0), 32'h0);
        chk("t1_valid_async", 32'(v0), 32'h0);
        step(); step();
        rst_n = 1'b1;
        step(); step();
        chk("t1_digits_after", dg0, 32'h0);
        chk("t1_count_after", 32'(c0), 32'h0);

        // Glitches: one-edge strobe, then a code change during debounce.
        code = 4'h3; strobe = 1'b1; step();
        strobe = 1'b0; step(); step();
        code = 4'h3; strobe = 1'b1; step();
        code = 4'h7; step();
        strobe = 1'b0; repeat (4) step();
        chk("t3_count", 32'(c0), 32'h0);
        chk("t3_digits", dg0, 32'h0);

        // Entry and backspace.
        press_key(4'h1); press_key(4'h2); press_key(4'h3);
        chk("t4_digits", dg0, 32'h123);
        chk("t4_count", 32'(c0), 32'h3);
        bksp = 1'b1; step();
        chk("t4_bksp_digits", dg0, 32'h12);
        chk("t4_bksp_count", 32'(c0), 32'h2);
        repeat (5) step();
        chk("t4_hold_digits", dg0, 32'h12);
        chk("t4_hold_count", 32'(c0), 32'h2);
        bksp = 1'b0; step();

        // Fill to capacity, then overflow (debounce 2 and 3 overflow on different edges).
        clr = 1'b1; step(); clr = 1'b0;
        press_key(4'hA); press_key(4'hB); press_key(4'hC); press_key(4'hD);
        press_key(4'hE); press_key(4'hF); press_key(4'h9); press_key(4'h8);
        chk("t5_digits_db3", dg1, 32'hABCDEF98);
        chk("t5_count_db3", 32'(c1), 32'h8);
        chk("t5_valid_db3", 32'(v1), 32'hFF);
        code = 4'h1; strobe = 1'b1;
        step();
        step();
        chk("t5_ovf_db2_e2", 32'(o0), 32'h1);
        chk("t5_ovf_db3_e2", 32'(o1), 32'h0);
        step();
        chk("t5_ovf_db3_e3", 32'(o1), 32'h1);
        chk("t5_press_db3_e3", 32'(p1), 32'h0);
        chk("t5_ovf_db2_e3", 32'(o0), 32'h0);
        step();
        strobe = 1'b0; repeat (4) step();
        chk("t5_digits_after", dg1, 32'hABCDEF98);
        chk("t5_count_after", 32'(c1), 32'h8);

        // clr, commit and backspace edge all on one edge: clr wins.
        code = 4'h4; strobe = 1'b1;
        step();
        clr = 1'b1; bksp = 1'b1;
        step();
        chk("t6_digits", dg0, 32'h0);
        chk("t6_count", 32'(c0), 32'h0);
        chk("t6_press", 32'(p0), 32'h0);
        chk("t6_ovf", 32'(o0), 32'h0);
        clr = 1'b0;
        step();
        strobe = 1'b0; repeat (4) step();
        bksp = 1'b0; step();
        bksp = 1'b1; step();
        chk("t6_bksp_noop_count", 32'(c0), 32'h0);
        chk("t6_bksp_noop_digits", dg0, 32'h0);
        bksp = 1'b0; step();

        // Randomized segments of press/release with glitches, backspace, rare clr and reset.
        for (int seg = 0; seg < 400; seg++) begin
            int len;
            len = $urandom_range(1, 6);
            strobe = ($urandom_range(0, 99) < 60);
            if ($urandom_range(0, 4) == 0) code = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 149) == 0) begin
                #1;
                rst_n = 1'b0; strobe = 1'b0;
                step();
                rst_n = 1'b1;
            end
            for (int c = 0; c < len; c++) begin
                clr = ($urandom_range(0, 149) == 0);
                if ($urandom_range(0, 7) == 0) bksp = ~bksp;
                if ($urandom_range(0, 19) == 0) code = 4'($urandom_range(0, 15));
                step();
            end
        end
        clr = 1'b0; strobe = 1'b0;
        repeat (4) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
